// File: rtl/rtc_alarm_ctrl_pkg.sv
// Shared types, BCD limits and helpers for the RTC daily alarm controller.
`default_nettype none

package rtc_alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

  localparam logic [3:0] HR_TENS_MAX      = 4'd2;
  localparam logic [3:0] HR_UNITS_MAX_20S = 4'd3;
  localparam logic [3:0] MIN_TENS_MAX     = 4'd5;
  localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic bcd_time_valid(input logic [3:0] hm, input logic [3:0] hl,
                                          input logic [3:0] mm, input logic [3:0] ml);
    return (hm <= HR_TENS_MAX) && (hl <= BCD_DIGIT_MAX) &&
           ((hm != HR_TENS_MAX) || (hl <= HR_UNITS_MAX_20S)) &&
           (mm <= MIN_TENS_MAX) && (ml <= BCD_DIGIT_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_alarm_ctrl_if.sv
// Bus bundle between the RTC counters / user controls and the alarm controller.
`default_nettype none

interface rtc_alarm_ctrl_if;
  logic [3:0] HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L;
  logic       set_en;
  logic [3:0] set_hr_m, set_hr_l, set_min_m, set_min_l;
  logic       arm, disarm, stop, snooze;
  logic       alarm_out, armed, snoozing, set_err;
  logic [1:0] snooze_cnt;
  logic [3:0] ALM_HR_M, ALM_HR_L, ALM_MIN_M, ALM_MIN_L;

  modport slave (
    input  HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L,
    input  set_en, set_hr_m, set_hr_l, set_min_m, set_min_l,
    input  arm, disarm, stop, snooze,
    output alarm_out, armed, snoozing, snooze_cnt, set_err,
    output ALM_HR_M, ALM_HR_L, ALM_MIN_M, ALM_MIN_L
  );

  modport master (
    output HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L,
    output set_en, set_hr_m, set_hr_l, set_min_m, set_min_l,
    output arm, disarm, stop, snooze,
    input  alarm_out, armed, snoozing, snooze_cnt, set_err,
    input  ALM_HR_M, ALM_HR_L, ALM_MIN_M, ALM_MIN_L
  );
endinterface

`default_nettype wire

// File: rtl/rtc_alarm_ctrl_sec_timer.sv
// Loadable, saturating down-counter shared by ring timeout and snooze countdown.
`default_nettype none

module rtc_sec_timer #(
  parameter int WIDTH = 9
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_value,
  input  wire logic             i_dec,
  output logic      [WIDTH-1:0] o_value,
  output logic                  o_zero
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_value;
    end else if (i_dec && (r_value != '0)) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == '0);

endmodule

`default_nettype wire

// File: rtl/rtc_alarm_ctrl.sv
// Daily alarm controller: BCD set validation, time comparator and arm/ring/snooze FSM.
`default_nettype none

module rtc_alarm_ctrl
  import rtc_alarm_ctrl_pkg::*;
#(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZES  = 3
) (
  input  wire logic        clk,
  input  wire logic        reset,
  rtc_alarm_ctrl_if.slave  bus
);

  localparam int c_TIMER_W = $clog2(max_int(SNOOZE_MIN * 60, RING_TIMEOUT));
  localparam logic [c_TIMER_W-1:0] c_RING_LOAD   = c_TIMER_W'(RING_TIMEOUT - 1);
  localparam logic [c_TIMER_W-1:0] c_SNOOZE_LOAD = c_TIMER_W'(SNOOZE_MIN * 60 - 1);

  state_t               r_state, w_next_state;
  logic [1:0]           r_snooze_cnt, w_snooze_cnt_next;
  logic                 r_set_err;
  logic [15:0]          r_alm;
  logic                 w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [c_TIMER_W-1:0] w_tmr_load_val, w_tmr_value;
  logic                 w_match, w_set_valid, w_snooze_ok;

  assign w_match = ({bus.HR_M, bus.HR_L, bus.MIN_M, bus.MIN_L} == r_alm) &&
                   (bus.SEC_M == 4'd0) && (bus.SEC_L == 4'd0);
  assign w_set_valid = bcd_time_valid(bus.set_hr_m, bus.set_hr_l, bus.set_min_m, bus.set_min_l);
  assign w_snooze_ok = int'(r_snooze_cnt) < MAX_SNOOZES;

  rtc_sec_timer #(.WIDTH(c_TIMER_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_load_val),
    .i_dec   (w_tmr_dec),
    .o_value (w_tmr_value),
    .o_zero  (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state      = r_state;
    w_snooze_cnt_next = r_snooze_cnt;
    w_tmr_load        = 1'b0;
    w_tmr_load_val    = '0;
    w_tmr_dec         = 1'b0;
    if (bus.disarm) begin
      w_next_state      = ST_IDLE;
      w_snooze_cnt_next = 2'd0;
      w_tmr_load        = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_snooze_cnt_next = 2'd0;
          if (bus.arm) w_next_state = ST_ARMED;
        end
        ST_ARMED: begin
          if (w_match) begin
            w_next_state      = ST_RINGING;
            w_snooze_cnt_next = 2'd0;
            w_tmr_load        = 1'b1;
            w_tmr_load_val    = c_RING_LOAD;
          end
        end
        ST_RINGING: begin
          if (bus.stop) begin
            w_next_state      = ST_ARMED;
            w_snooze_cnt_next = 2'd0;
          end else if (bus.snooze && w_snooze_ok) begin
            w_next_state      = ST_SNOOZE;
            w_snooze_cnt_next = r_snooze_cnt + 2'd1;
            w_tmr_load        = 1'b1;
            w_tmr_load_val    = c_SNOOZE_LOAD;
          end else if (w_tmr_zero) begin
            w_next_state      = ST_ARMED;
            w_snooze_cnt_next = 2'd0;
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (bus.stop) begin
            w_next_state      = ST_ARMED;
            w_snooze_cnt_next = 2'd0;
          end else if (w_tmr_zero) begin
            w_next_state   = ST_RINGING;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = c_RING_LOAD;
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // set_en is judged against the current state, so a set in the same clock as arm still loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snooze_cnt <= 2'd0;
      r_set_err    <= 1'b0;
      r_alm        <= 16'h0000;
    end else begin
      r_snooze_cnt <= w_snooze_cnt_next;
      r_set_err    <= bus.set_en && ((r_state != ST_IDLE) || !w_set_valid);
      if (bus.set_en && (r_state == ST_IDLE) && w_set_valid)
        r_alm <= {bus.set_hr_m, bus.set_hr_l, bus.set_min_m, bus.set_min_l};
    end
  end

  assign bus.alarm_out  = (r_state == ST_RINGING);
  assign bus.armed      = (r_state != ST_IDLE);
  assign bus.snoozing   = (r_state == ST_SNOOZE);
  assign bus.snooze_cnt = r_snooze_cnt;
  assign bus.set_err    = r_set_err;
  assign {bus.ALM_HR_M, bus.ALM_HR_L, bus.ALM_MIN_M, bus.ALM_MIN_L} = r_alm;

endmodule

`default_nettype wire

// File: tb/tb_rtc_alarm_ctrl.sv
// Self-checking bench for rtc_alarm_ctrl: set-time vector table plus ring/snooze sequences.
`default_nettype none

module tb_rtc_alarm_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  rtc_alarm_ctrl_if bif ();

  rtc_alarm_ctrl #(
    .SNOOZE_MIN   (5),
    .RING_TIMEOUT (60),
    .MAX_SNOOZES  (3)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] set_time;
    logic        exp_err;
    logic [15:0] exp_alm;
  } set_vec_t;

  set_vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_live(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    {bif.HR_M, bif.HR_L}   = hh;
    {bif.MIN_M, bif.MIN_L} = mm;
    {bif.SEC_M, bif.SEC_L} = ss;
  endtask

  function automatic logic [15:0] alm();
    return {bif.ALM_HR_M, bif.ALM_HR_L, bif.ALM_MIN_M, bif.ALM_MIN_L};
  endfunction

  // Presents 07:30:00 for one edge then moves time on so the event cannot re-fire.
  task automatic ring_now();
    set_live(8'h07, 8'h30, 8'h00);
    tick();
    set_live(8'h07, 8'h30, 8'h01);
  endtask

  task automatic apply_set(input logic [15:0] t);
    {bif.set_hr_m, bif.set_hr_l, bif.set_min_m, bif.set_min_l} = t;
    bif.set_en = 1'b1;
    tick();
    bif.set_en = 1'b0;
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{16'h0730, 1'b0, 16'h0730};
    vecs[1] = '{16'h2400, 1'b1, 16'h0730};
    vecs[2] = '{16'h1975, 1'b1, 16'h0730};
    vecs[3] = '{16'h2359, 1'b0, 16'h2359};
    vecs[4] = '{16'h1A00, 1'b1, 16'h2359};
    vecs[5] = '{16'h2060, 1'b1, 16'h2359};
    vecs[6] = '{16'h3000, 1'b1, 16'h2359};
    vecs[7] = '{16'h0000, 1'b0, 16'h0000};
    vecs[8] = '{16'h0730, 1'b0, 16'h0730};

    reset = 1'b1;
    bif.set_en = 1'b0; bif.arm = 1'b0; bif.disarm = 1'b0; bif.stop = 1'b0; bif.snooze = 1'b0;
    {bif.set_hr_m, bif.set_hr_l, bif.set_min_m, bif.set_min_l} = 16'h0000;
    set_live(8'h12, 8'h00, 8'h05);
    tick(); tick();
    reset = 1'b0;
    check("reset_outputs", {bif.alarm_out, bif.armed, bif.snoozing, bif.snooze_cnt, bif.set_err}, 0);
    check("reset_alm", alm(), 16'h0000);

    for (int i = 0; i < 9; i++) begin
      apply_set(vecs[i].set_time);
      check($sformatf("set_err_v%0d", i), bif.set_err, vecs[i].exp_err);
      check($sformatf("alm_v%0d", i), alm(), vecs[i].exp_alm);
      tick();
      check($sformatf("set_err_clr_v%0d", i), bif.set_err, 0);
    end

    // Test 1: match ring one clock after 07:30:00
    bif.arm = 1'b1; tick(); bif.arm = 1'b0;
    check("armed_after_arm", bif.armed, 1);
    set_live(8'h07, 8'h29, 8'h59); tick();
    check("no_ring_at_2959", bif.alarm_out, 0);
    ring_now();
    check("ring_after_match", {bif.alarm_out, bif.armed}, 2'b11);

    // Test 2: auto-silence after exactly 60 ringing clocks
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bif.alarm_out) cnt++;
      else break;
    end
    check("ring_length", cnt, 60);
    check("after_timeout", {bif.alarm_out, bif.armed, bif.snooze_cnt}, 4'b0100);

    // set_en while ARMED is rejected
    apply_set(16'h1200);
    check("set_err_armed", bif.set_err, 1);
    check("alm_kept_armed", alm(), 16'h0730);

    // Test 3: snooze at ring clock 5, three times, fourth ignored
    ring_now();
    tick(); tick(); tick();
    for (int s = 1; s <= 3; s++) begin
      bif.snooze = 1'b1; tick(); bif.snooze = 1'b0;
      check($sformatf("snooze_state_%0d", s), {bif.snoozing, bif.alarm_out, bif.snooze_cnt}, {2'b10, 2'(s)});
      cnt = 1;
      for (int i = 0; i < 400; i++) begin
        tick();
        if (bif.snoozing) cnt++;
        else break;
      end
      check($sformatf("snooze_len_%0d", s), cnt, 300);
      check($sformatf("ring_resume_%0d", s), {bif.alarm_out, bif.snooze_cnt}, {1'b1, 2'(s)});
    end
    bif.snooze = 1'b1; tick(); bif.snooze = 1'b0;
    check("snooze4_ignored", {bif.alarm_out, bif.snoozing, bif.snooze_cnt}, 4'b1011);
    bif.stop = 1'b1; tick(); bif.stop = 1'b0;
    check("stop_to_armed", {bif.alarm_out, bif.armed, bif.snooze_cnt}, 4'b0100);

    // Test 5: stop wins over snooze; disarm from SNOOZE
    ring_now();
    bif.stop = 1'b1; bif.snooze = 1'b1; tick(); bif.stop = 1'b0; bif.snooze = 1'b0;
    check("stop_and_snooze", {bif.alarm_out, bif.armed, bif.snoozing, bif.snooze_cnt}, 5'b01000);
    ring_now();
    bif.snooze = 1'b1; tick(); bif.snooze = 1'b0;
    check("snooze_before_disarm", {bif.snoozing, bif.snooze_cnt}, 3'b101);
    tick(); tick();
    bif.disarm = 1'b1; tick(); bif.disarm = 1'b0;
    check("disarm_from_snooze", {bif.alarm_out, bif.armed, bif.snoozing, bif.snooze_cnt}, 5'b00000);

    // Test 6: reset mid-ring clears everything, 00:00:00 then does not ring
    bif.arm = 1'b1; tick(); bif.arm = 1'b0;
    ring_now();
    check("ring_before_reset", bif.alarm_out, 1);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_midring_out", {bif.alarm_out, bif.armed, bif.snoozing, bif.snooze_cnt, bif.set_err}, 0);
    check("reset_midring_alm", alm(), 16'h0000);
    set_live(8'h00, 8'h00, 8'h00); tick();
    set_live(8'h00, 8'h00, 8'h01); tick();
    check("idle_no_ring", {bif.alarm_out, bif.armed}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
